fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//  Consumer of the hazard unit's PCSrc / IF_ID_stall / IF_ID_flush outputs: owns the PC register,
//  the instruction-memory fetch handshake and the IF/ID pipeline register. Sits between imem and
//  the ID stage; applies redirect, stall and bubble insertion cycle-accurately.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_WORD   32'h0000_0000  instruction word placed in IF/ID for a bubble (sll $0,$0,0)
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  pc_src         in   3   000 seq (PC+4), 001 jump, 010 branch; 011..111 reserved -> treated as 000
//  jump_target    in   32  jump destination, sampled when pc_src==001
//  branch_target  in   32  branch destination, sampled when pc_src==010
//  if_id_stall    in   1   hold PC and IF/ID (load-use)
//  if_id_flush    in   1   replace IF/ID contents with bubble
//  imem_addr      out  32  fetch address (= PC); stable while imem_ready==0
//  imem_rdata     in   32  instruction word, valid when imem_ready==1
//  imem_ready     in   1   fetch completes this cycle
//  if_id_instr    out  32  IF/ID instruction
//  if_id_pc4      out  32  IF/ID PC+4
//  if_id_valid    out  1   0 = bubble
//  stall_cnt      out  32  cycles with if_id_stall==1 (FETCH_PERF_EN only)
//  redirect_cnt   out  32  accepted redirects (FETCH_PERF_EN only)
// BEHAVIOUR
//  Reset (rst==1 at edge): PC=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, state=RUN,
//   saved target=0, counters=0. Reset overrides every other input, including mid-WAIT_REDIR.
//  States: RUN, WAIT_REDIR.
//  RUN, per-edge priority redirect > stall > ready:
//   - redirect (pc_src 001/010) with imem_ready==1: PC<=target; IF/ID<=bubble (valid=0, NOP_WORD,
//     pc4=0). Overrides if_id_stall and if_id_flush. Stay RUN.
//   - redirect with imem_ready==0: PC held (address stability); target latched in saved target;
//     IF/ID<=bubble; -> WAIT_REDIR.
//   - stall, no redirect: PC and IF/ID hold (if_id_flush also set -> IF/ID<=bubble, PC holds).
//   - no redirect/stall, imem_ready==1: PC<=PC+4; IF/ID<={imem_rdata, PC+4, valid=1}, unless
//     if_id_flush==1 -> IF/ID<=bubble while PC still advances.
//   - no redirect/stall, imem_ready==0: PC holds; IF/ID<=bubble.
//  WAIT_REDIR:
//   - PC (imem_addr) held; IF/ID<=bubble every cycle; stall/flush ignored.
//   - new redirect while imem_ready==0: saved target overwritten by latest target.
//   - imem_ready==1: returned word discarded; PC<=saved target (or the new target if a redirect is
//     present the same cycle); -> RUN.
//  Arithmetic: PC+4 modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000, no flag). Targets used as given;
//   bits[1:0] not checked.
//  Latency: fetched word appears on IF/ID one edge after the imem_ready==1 cycle; redirect takes
//   effect on imem_addr one edge after pc_src asserted; exactly one bubble per redirect in RUN.
//  imem_addr driven directly from PC register (no combinational path from inputs).
// CONFIGURATION
//  FETCH_PERF_EN defined: stall_cnt +1 each edge with if_id_stall==1 (not rst); redirect_cnt +1
//   per redirect accepted in RUN (latest-wins overwrite in WAIT_REDIR not counted); both saturate
//   at 32'hFFFF_FFFF; cleared by rst.
//  FETCH_PERF_EN undefined: no counter flops; stall_cnt and redirect_cnt tied to 32'h0.
// TESTING
//  1 rst=1 two cycles, imem_ready=1 -> imem_addr=0x0, if_id_valid=0, if_id_instr=0x0 after release.
//  2 ready=1, rdata=addr^0xA5A5_0000 -> if_id_pc4 = 4,8,0xC on successive edges, valid=1, instr matches.
//  3 if_id_stall=1 for 2 cycles at PC=0x10 -> imem_addr stays 0x10, IF/ID holds pc4=0x10; resumes 0x14.
//  4 pc_src=010, branch_target=0x100 with if_id_stall=1 -> next imem_addr=0x100, if_id_valid=0.
//  5 PC=0x20, ready=0 3 cycles, pc_src=001 jump_target=0x200 in cycle 1, then 0x300 in cycle 2 ->
//    imem_addr=0x20 until ready, valid=0 throughout, then imem_addr=0x300.
//  6 FETCH_PERF_EN: 5 stall cycles + 2 redirects -> stall_cnt=5, redirect_cnt=2; undefined -> both 0.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register, imem fetch handshake and IF/ID register.
// Optional stall/redirect counters are built when FETCH_PERF_EN is defined.
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  pc_src,
   input  logic [31:0] jump_target,
   input  logic [31:0] branch_target,
   input  logic        if_id_stall,
   input  logic        if_id_flush,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] stall_cnt,
   output logic [31:0] redirect_cnt
);

   typedef enum logic {
      RUN,
      WAIT_REDIR
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redir;
   logic [31:0] redir_tgt;
   logic [31:0] pc_plus4;
   logic        accept;
   logic        hold;
   logic        load;

   assign pc_plus4 = pc_q + 32'd4;

   // Reserved pc_src encodings fall through to sequential fetch.
   always_comb begin
      redir     = 1'b0;
      redir_tgt = jump_target;
      unique case (pc_src)
         3'b001: begin
            redir     = 1'b1;
            redir_tgt = jump_target;
         end
         3'b010: begin
            redir     = 1'b1;
            redir_tgt = branch_target;
         end
         default: begin
            redir     = 1'b0;
            redir_tgt = jump_target;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      accept  = 1'b0;
      hold    = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (redir) begin
               accept = 1'b1;
               if (imem_ready) begin
                  pc_d = redir_tgt;
               end else begin
                  // Address must stay put until imem completes.
                  tgt_d   = redir_tgt;
                  state_d = WAIT_REDIR;
               end
            end else if (if_id_stall) begin
               hold = !if_id_flush;
            end else if (imem_ready) begin
               pc_d = pc_plus4;
               load = !if_id_flush;
            end
         end
         WAIT_REDIR: begin
            if (imem_ready) begin
               pc_d    = redir ? redir_tgt : tgt_q;
               state_d = RUN;
            end else if (redir) begin
               tgt_d = redir_tgt;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (hold) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (load) begin
         instr_d = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] redir_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'h0;
         redir_cnt_q <= 32'h0;
      end else begin
         if (if_id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (accept && (redir_cnt_q != 32'hFFFF_FFFF)) begin
            redir_cnt_q <= redir_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign redirect_cnt = redir_cnt_q;
`else
   logic unused_accept;

   assign unused_accept = accept;
   assign stall_cnt     = 32'h0;
   assign redirect_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: scoreboard bench for fetch_stage_ctrl.
// Counter expectations follow FETCH_PERF_EN.
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  pc_src;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic        if_id_stall;
   logic        if_id_flush;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] stall_cnt;
   logic [31:0] redirect_cnt;

   always #5 clk = ~clk;

   fetch_stage_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_src       (pc_src),
      .jump_target  (jump_target),
      .branch_target(branch_target),
      .if_id_stall  (if_id_stall),
      .if_id_flush  (if_id_flush),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .if_id_instr  (if_id_instr),
      .if_id_pc4    (if_id_pc4),
      .if_id_valid  (if_id_valid),
      .stall_cnt    (stall_cnt),
      .redirect_cnt (redirect_cnt)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   localparam logic [31:0] K = 32'hA5A5_0000;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic drive(input logic r, input logic [2:0] s,
                        input logic [31:0] jt, input logic [31:0] bt,
                        input logic st, input logic fl,
                        input logic rdy, input logic [31:0] rd);
      rst           = r;
      pc_src        = s;
      jump_target   = jt;
      branch_target = bt;
      if_id_stall   = st;
      if_id_flush   = fl;
      imem_ready    = rdy;
      imem_rdata    = rd;
   endtask

   function automatic exp_t bub(input logic [31:0] a);
      return exp_t'{a, 1'b0, 32'h0, 32'h0};
   endfunction

   function automatic exp_t fet(input logic [31:0] a);
      return exp_t'{a + 32'd4, 1'b1, a ^ K, a + 32'd4};
   endfunction

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1, 3'b000, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
         sb.push_back(bub(32'h0));
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL reset[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
      n_run++;
      if (stall_cnt !== 32'h0 || redirect_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, redirect_cnt);
      end
   endtask

   task automatic test_seq();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(0, 3'b000, 0, 0, 0, 0, 1, 32'(i * 4) ^ K);
         sb.push_back(fet(32'(i * 4)));
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL seq[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
   endtask

   task automatic test_stall();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(0, 3'b000, 0, 0, (i < 2), 0, 1, 32'h10 ^ K);
         if (i < 2) sb.push_back(exp_t'{32'h10, 1'b1, 32'hC ^ K, 32'h10});
         else       sb.push_back(fet(32'h10));
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL stall[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
   endtask

   task automatic test_redirect();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin
               drive(0, 3'b010, 32'h999, 32'h100, 1, 0, 1, 32'h14 ^ K);
               sb.push_back(bub(32'h100));
            end
            1: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'h100 ^ K);
               sb.push_back(fet(32'h100));
            end
            2: begin
               drive(0, 3'b000, 0, 0, 0, 1, 1, 32'h104 ^ K);
               sb.push_back(bub(32'h108));
            end
            3: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'h108 ^ K);
               sb.push_back(fet(32'h108));
            end
            4: begin
               drive(0, 3'b000, 0, 0, 1, 1, 1, 32'h10C ^ K);
               sb.push_back(bub(32'h10C));
            end
            5: begin
               drive(0, 3'b000, 0, 0, 0, 0, 0, 32'h10C ^ K);
               sb.push_back(bub(32'h10C));
            end
            6: begin
               drive(0, 3'b111, 32'h700, 32'h800, 0, 0, 1, 32'h10C ^ K);
               sb.push_back(fet(32'h10C));
            end
            default: begin
               drive(0, 3'b001, 32'h20, 32'h900, 0, 1, 1, 32'h110 ^ K);
               sb.push_back(bub(32'h20));
            end
         endcase
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL redirect[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
   endtask

   task automatic test_wait();
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         case (i)
            0: begin
               drive(0, 3'b001, 32'h200, 0, 0, 0, 0, 32'hBAD0);
               sb.push_back(bub(32'h20));
            end
            1: begin
               drive(0, 3'b001, 32'h300, 0, 0, 0, 0, 32'hBAD1);
               sb.push_back(bub(32'h20));
            end
            2: begin
               drive(0, 3'b000, 0, 0, 1, 0, 0, 32'hBAD2);
               sb.push_back(bub(32'h20));
            end
            3: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'hBAD3);
               sb.push_back(bub(32'h300));
            end
            4: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'h300 ^ K);
               sb.push_back(fet(32'h300));
            end
            5: begin
               drive(0, 3'b010, 0, 32'h400, 0, 0, 0, 32'hBAD5);
               sb.push_back(bub(32'h304));
            end
            6: begin
               drive(0, 3'b010, 0, 32'h500, 0, 0, 1, 32'hBAD6);
               sb.push_back(bub(32'h500));
            end
            7: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'h500 ^ K);
               sb.push_back(fet(32'h500));
            end
            8: begin
               drive(0, 3'b001, 32'h600, 0, 0, 0, 0, 32'hBAD8);
               sb.push_back(bub(32'h504));
            end
            9: begin
               drive(1, 3'b000, 0, 0, 0, 0, 0, 32'hBAD9);
               sb.push_back(bub(32'h0));
            end
            default: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, 32'h0 ^ K);
               sb.push_back(fet(32'h0));
            end
         endcase
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL wait[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            drive(0, 3'b001, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h4 ^ K);
            sb.push_back(bub(32'hFFFF_FFFC));
         end else begin
            drive(0, 3'b000, 0, 0, 0, 0, 1, 32'hFFFF_FFFC ^ K);
            sb.push_back(exp_t'{32'h0, 1'b1, 32'h5A5A_FFFC, 32'h0});
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
      end
   endtask

   task automatic test_perf();
      exp_t        e;
      logic [31:0] es;
      logic [31:0] er;
      for (int i = 0; i < 11; i++) begin
         case (i)
            0: begin
               drive(1, 3'b000, 0, 0, 1, 0, 1, K);
               sb.push_back(bub(32'h0));
            end
            1, 2, 3, 4, 5: begin
               drive(0, 3'b000, 0, 0, 1, 0, 1, K);
               sb.push_back(bub(32'h0));
            end
            6: begin
               drive(0, 3'b001, 32'h40, 0, 0, 0, 1, K);
               sb.push_back(bub(32'h40));
            end
            7: begin
               drive(0, 3'b010, 0, 32'h80, 0, 0, 1, K);
               sb.push_back(bub(32'h80));
            end
            8: begin
               drive(0, 3'b001, 32'hC0, 0, 0, 0, 0, K);
               sb.push_back(bub(32'h80));
            end
            9: begin
               drive(0, 3'b001, 32'hD0, 0, 0, 0, 0, K);
               sb.push_back(bub(32'h80));
            end
            default: begin
               drive(0, 3'b000, 0, 0, 0, 0, 1, K);
               sb.push_back(bub(32'hD0));
            end
         endcase
         @(posedge clk); #1;
         e = sb.pop_front();
         n_run++;
         if ({imem_addr, if_id_valid, if_id_instr, if_id_pc4} !== e) begin
            n_fail++;
            $display("FAIL perf[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", i,
                     imem_addr, if_id_valid, if_id_instr, if_id_pc4,
                     e.addr, e.valid, e.instr, e.pc4);
         end
         if (i == 0 || i == 7 || i == 10) begin
`ifdef FETCH_PERF_EN
            es = (i == 0) ? 32'd0 : 32'd5;
            er = (i == 0) ? 32'd0 : ((i == 7) ? 32'd2 : 32'd3);
`else
            es = 32'd0;
            er = 32'd0;
`endif
            n_run++;
            if (stall_cnt !== es || redirect_cnt !== er) begin
               n_fail++;
               $display("FAIL perf_cnt[%0d] got %0d/%0d want %0d/%0d", i,
                        stall_cnt, redirect_cnt, es, er);
            end
         end
      end
   endtask

   initial begin
      drive(1, 3'b000, 0, 0, 0, 0, 1, 32'h0);
      test_reset();
      test_seq();
      test_stall();
      test_redirect();
      test_wait();
      test_wrap();
      test_perf();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
